// File: rtl/fifo_unpacker.sv
// Read-side consumer for the first-word-fall-through FIFO: pops WIDTH-bit words
// and streams them out as WIDTH/OUT_WIDTH chunks on a valid/ready interface.
module fifo_unpacker #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_re,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 idle
);

    localparam int RATIO = WIDTH / OUT_WIDTH;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    generate
        if ((WIDTH % OUT_WIDTH) != 0 || OUT_WIDTH <= 0) begin : g_bad_ratio
            $error("fifo_unpacker: WIDTH must be a whole multiple of OUT_WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] word_q;
    logic [CW-1:0]    cnt;
    logic             valid_q;
    logic             acc;

    // Chunks laid out in emission order so the chunk index selects directly.
    logic [OUT_WIDTH-1:0] chunks [RATIO];

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_chunk
            if (MSB_FIRST) begin : g_msb
                assign chunks[gi] = word_q[WIDTH-1-gi*OUT_WIDTH -: OUT_WIDTH];
            end else begin : g_lsb
                assign chunks[gi] = word_q[gi*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    endgenerate

    assign out_valid = valid_q;
    assign out_data  = chunks[cnt];
    assign out_last  = valid_q & (cnt == CW'(RATIO - 1));
    assign acc       = valid_q & out_ready;

    // A pop happens only when the slot is free or is being vacated this cycle,
    // which gives back-to-back words with no bubble; the FIFO is never popped empty.
    assign fifo_re = !rst & !flush & !fifo_empty & (!valid_q | (acc & out_last));
    assign idle    = !rst & !valid_q & fifo_empty;

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    // NOTE: word_q is a single datapath register, so resetting it is cheap and
    // keeps out_data deterministic after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            cnt     <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            // Flush wins over an accept: the presented chunk is dropped.
            cnt     <= '0;
            valid_q <= 1'b0;
        end else if (fifo_re) begin
            word_q  <= fifo_data;
            cnt     <= '0;
            valid_q <= 1'b1;
        end else if (acc) begin
            if (out_last) begin
                cnt     <= '0;
                valid_q <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
